// File: rtl/cpu.sv
// Single-cycle 16-bit WISC-F18 core with private instruction and data memories.
module cpu (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  output logic        hlt
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  logic [15:0] rf   [0:15];

  logic        flag_z, flag_v, flag_n;
  logic [15:0] instr;
  opcode_t     op;
  logic [3:0]  rd, rs, rt;
  logic [15:0] rd_val, rs_val, rt_val;
  logic [15:0] pc_plus2;
  logic [14:0] mem_word;
  logic [15:0] mem_rdata;
  logic        taken;

  logic [15:0] result;
  logic [15:0] next_pc;
  logic        rf_we, dmem_we;
  logic        z_we, v_we, n_we;
  logic        z_new, v_new, n_new;
  logic [16:0] sum17;
  logic [4:0]  nib;

  assign instr    = imem[pc[15:1]];
  assign op       = opcode_t'(instr[15:12]);
  assign rd       = instr[11:8];
  assign rs       = instr[7:4];
  assign rt       = instr[3:0];
  assign rd_val   = (rd == 4'd0) ? 16'h0000 : rf[rd];
  assign rs_val   = (rs == 4'd0) ? 16'h0000 : rf[rs];
  assign rt_val   = (rt == 4'd0) ? 16'h0000 : rf[rt];
  assign pc_plus2 = pc + 16'd2;

  // Word address of (rs & 0xFFFE) + (sext(imm4) << 1); the byte bit is always zero.
  assign mem_word  = rs_val[15:1] + {{11{rt[3]}}, rt};
  assign mem_rdata = dmem[mem_word];

  assign hlt = rst_n & (op == OP_HLT);

  always_comb begin
    taken = 1'b0;
    case (instr[11:9])
      3'b000: taken = !flag_z;
      3'b001: taken = flag_z;
      3'b010: taken = !flag_z && !flag_n;
      3'b011: taken = flag_n;
      3'b100: taken = flag_z || !flag_n;
      3'b101: taken = flag_n || flag_z;
      3'b110: taken = flag_v;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    result  = 16'h0000;
    next_pc = pc_plus2;
    rf_we   = 1'b0;
    dmem_we = 1'b0;
    z_we    = 1'b0;
    v_we    = 1'b0;
    n_we    = 1'b0;
    z_new   = 1'b0;
    v_new   = 1'b0;
    n_new   = 1'b0;
    sum17   = 17'd0;
    nib     = 5'd0;
    case (op)
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD)
          sum17 = {rs_val[15], rs_val} + {rt_val[15], rt_val};
        else
          sum17 = {rs_val[15], rs_val} - {rt_val[15], rt_val};
        if (sum17[16] ^ sum17[15])
          result = sum17[16] ? 16'h8000 : 16'h7FFF;
        else
          result = sum17[15:0];
        rf_we = 1'b1;
        z_we  = 1'b1;
        v_we  = 1'b1;
        n_we  = 1'b1;
        z_new = (result == 16'h0000);
        v_new = sum17[16] ^ sum17[15];
        n_new = result[15];
      end
      OP_XOR: begin
        result = rs_val ^ rt_val;
        rf_we  = 1'b1;
        z_we   = 1'b1;
        z_new  = (result == 16'h0000);
      end
      OP_RED: begin
        result = {{8{rs_val[15]}}, rs_val[15:8]} + {{8{rt_val[15]}}, rt_val[15:8]}
               + {{8{rs_val[7]}},  rs_val[7:0]}  + {{8{rt_val[7]}},  rt_val[7:0]};
        rf_we  = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        if (op == OP_SLL)
          result = rs_val << rt;
        else if (op == OP_SRA)
          result = $signed(rs_val) >>> rt;
        else
          result = (rs_val >> rt) | (rs_val << (5'd16 - {1'b0, rt}));
        rf_we = 1'b1;
        z_we  = 1'b1;
        z_new = (result == 16'h0000);
      end
      OP_PADDSB: begin
        for (int i = 0; i < 4; i++) begin
          nib = {rs_val[4*i+3], rs_val[4*i+:4]} + {rt_val[4*i+3], rt_val[4*i+:4]};
          if (nib[4] ^ nib[3])
            result[4*i+:4] = nib[4] ? 4'h8 : 4'h7;
          else
            result[4*i+:4] = nib[3:0];
        end
        rf_we = 1'b1;
      end
      OP_LW: begin
        result = mem_rdata;
        rf_we  = 1'b1;
      end
      OP_SW:  dmem_we = 1'b1;
      OP_LLB: begin
        result = {rd_val[15:8], instr[7:0]};
        rf_we  = 1'b1;
      end
      OP_LHB: begin
        result = {instr[7:0], rd_val[7:0]};
        rf_we  = 1'b1;
      end
      OP_B: begin
        if (taken)
          next_pc = pc_plus2 + {{6{instr[8]}}, instr[8:0], 1'b0};
      end
      OP_BR: begin
        if (taken)
          next_pc = rs_val;
      end
      OP_PCS: begin
        result = pc_plus2;
        rf_we  = 1'b1;
      end
      OP_HLT:  next_pc = pc;
      default: next_pc = pc_plus2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= 16'h0000;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
      for (int i = 0; i < 16; i++)
        rf[i] <= 16'h0000;
    end else begin
      pc <= next_pc;
      if (z_we) flag_z <= z_new;
      if (v_we) flag_v <= v_new;
      if (n_we) flag_n <= n_new;
      if (rf_we && (rd != 4'd0))
        rf[rd] <= result;
    end
  end

  // Data memory is never cleared; stores are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (dmem_we && rst_n)
      dmem[mem_word] <= rd_val;
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: an ISA-level reference interpreter predicts the
// per-cycle pc/hlt trace into a scoreboard queue that a monitor drains.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic        hlt;

  cpu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc),
    .hlt   (hlt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        hlt;
  } exp_t;

  exp_t        exp_q [$];
  bit          armed = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic [15:0] prog [$];
  logic [15:0] m_imem [32768];
  logic [15:0] m_dmem [32768];
  logic [15:0] m_rf [16];
  bit          mz, mv, mn;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("trace_pc", pc, e.pc);
      check_output("trace_hlt", {15'd0, hlt}, {15'd0, e.hlt});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at pc=%h", pc);
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: ISA semantics in plain integer arithmetic.
  function automatic int sx(input int x, input int bits);
    int v;
    v = x & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return v;
  endfunction

  function automatic logic [15:0] rr(input int i);
    return (i == 0) ? 16'h0000 : m_rf[i];
  endfunction

  function automatic bit cond_met(input int c);
    case (c)
      0: return !mz;
      1: return mz;
      2: return !mz && !mn;
      3: return mn;
      4: return mz || !mn;
      5: return mn || mz;
      6: return mv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_run();
    int mpc, nxt, op, rdi, rsi, rti, s, addr;
    logic [15:0] ins, a, b, d, res;
    bit wr;
    exp_t e;
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    mz = 0; mv = 0; mn = 0;
    mpc = 0;
    for (int step = 0; step < 1000; step++) begin
      ins = m_imem[mpc >> 1];
      op  = int'(ins[15:12]);
      rdi = int'(ins[11:8]);
      rsi = int'(ins[7:4]);
      rti = int'(ins[3:0]);
      e.pc  = 16'(mpc);
      e.hlt = (op == 15);
      exp_q.push_back(e);
      if (op == 15) begin
        repeat (3) exp_q.push_back(e);
        break;
      end
      a = rr(rsi); b = rr(rti); d = rr(rdi);
      nxt = mpc + 2;
      wr = 1'b1;
      res = 16'h0000;
      case (op)
        0, 1: begin
          s = (op == 0) ? sx(a, 16) + sx(b, 16) : sx(a, 16) - sx(b, 16);
          mv = (s > 32767) || (s < -32768);
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          res = 16'(s);
          mz = (s == 0);
          mn = (s < 0);
        end
        2: begin res = a ^ b; mz = (res == 0); end
        3: res = 16'(sx(a >> 8, 8) + sx(b >> 8, 8) + sx(a, 8) + sx(b, 8));
        4: begin res = 16'(int'(a) << rti); mz = (res == 0); end
        5: begin s = sx(a, 16) >>> rti; res = 16'(s); mz = (res == 0); end
        6: begin res = 16'((int'(a) >> rti) | (int'(a) << (16 - rti))); mz = (res == 0); end
        7: begin
          for (int k = 0; k < 4; k++) begin
            s = sx(a >> (4 * k), 4) + sx(b >> (4 * k), 4);
            if (s > 7) s = 7;
            if (s < -8) s = -8;
            res = res | 16'((s & 15) << (4 * k));
          end
        end
        8, 9: begin
          addr = ((int'(a) & 'hFFFE) + sx(rti, 4) * 2) & 'hFFFF;
          if (op == 8) res = m_dmem[addr >> 1];
          else begin m_dmem[addr >> 1] = d; wr = 1'b0; end
        end
        10: res = (d & 16'hFF00) | 16'(ins & 16'h00FF);
        11: res = (d & 16'h00FF) | 16'((ins & 16'h00FF) << 8);
        12: begin
          wr = 1'b0;
          if (cond_met(int'(ins[11:9]))) nxt = mpc + 2 + sx(int'(ins[8:0]), 9) * 2;
        end
        13: begin
          wr = 1'b0;
          if (cond_met(int'(ins[11:9]))) nxt = int'(a);
        end
        default: res = 16'(mpc + 2);
      endcase
      if (wr && rdi != 0) m_rf[rdi] = res;
      mpc = nxt & 'hFFFF;
    end
  endtask

  task automatic load_program();
    logic [15:0] v;
    for (int i = 0; i < 512; i++) begin
      dut.imem[i] = 16'hF000;
      m_imem[i]   = 16'hF000;
    end
    for (int i = 0; i < prog.size(); i++) begin
      dut.imem[i] = prog[i];
      m_imem[i]   = prog[i];
    end
    for (int i = 0; i < 32768; i++) begin
      v = 16'($urandom);
      dut.dmem[i] = v;
      m_dmem[i]   = v;
    end
  endtask

  task automatic gen_program(input bit no_store);
    int sel;
    logic [3:0] op;
    logic [15:0] ins;
    prog.delete();
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 5)       op = (sel < 3) ? 4'hA : 4'hB;
      else if (sel < 13) op = 4'($urandom_range(0, 7));
      else if (sel < 15) op = 4'h8;
      else if (sel < 17) op = no_store ? 4'h8 : 4'h9;
      else if (sel < 19) op = 4'hC;
      else               op = 4'hE;
      if (op == 4'hC)
        ins = {4'hC, 3'($urandom_range(0, 7)), 9'($urandom_range(0, 6))};
      else
        ins = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      prog.push_back(ins);
    end
    prog.push_back(16'hF000);
  endtask

  // Runs the loaded program from reset; abort_after > 0 re-asserts reset mid-run.
  task automatic apply_stimulus(input int abort_after);
    int budget;
    int diff;
    #1;
    check_output("reset_pc", pc, 16'h0000);
    check_output("reset_hlt", {15'd0, hlt}, 16'h0000);
    exp_q.delete();
    model_run();
    @(posedge clk);
    #1 rst_n = 1'b1;
    armed = 1'b1;
    if (abort_after > 0) begin
      repeat (abort_after) @(posedge clk);
      #2 rst_n = 1'b0;
      armed = 1'b0;
      #1;
      check_output("mid_reset_pc", pc, 16'h0000);
      check_output("mid_reset_hlt", {15'd0, hlt}, 16'h0000);
      exp_q.delete();
      return;
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout remaining=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    armed = 1'b0;
    #1;
    for (int i = 1; i < 16; i++)
      check_output($sformatf("reg_r%0d", i), dut.rf[i], m_rf[i]);
    check_output("flag_z", {15'd0, dut.flag_z}, {15'd0, mz});
    check_output("flag_v", {15'd0, dut.flag_v}, {15'd0, mv});
    check_output("flag_n", {15'd0, dut.flag_n}, {15'd0, mn});
    diff = 0;
    for (int i = 0; i < 32768; i++)
      if (dut.dmem[i] !== m_dmem[i]) diff++;
    check_output("dmem_diff_words", 16'(diff), 16'd0);
  endtask

  task automatic reset_while_halted();
    #2 rst_n = 1'b0;
    #1;
    check_output("halt_reset_pc", pc, 16'h0000);
    check_output("halt_reset_hlt", {15'd0, hlt}, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      dut.imem[i] = 16'hF000;
      m_imem[i]   = 16'hF000;
    end
    #12;

    prog = '{16'hF000};
    load_program();
    apply_stimulus(0);
    reset_while_halted();

    prog = '{16'hA134, 16'hB112, 16'h0211, 16'hA1FF, 16'hB17F, 16'h0311, 16'hCC02,
             16'hF000, 16'hF000, 16'h9102, 16'h8502, 16'hA640, 16'h1411, 16'hD260};
    while (prog.size() < 32) prog.push_back(16'hF000);
    prog.push_back(16'hE700);
    prog.push_back(16'hA977);
    prog.push_back(16'hB977);
    prog.push_back(16'hAA11);
    prog.push_back(16'hBA11);
    prog.push_back(16'h789A);
    prog.push_back(16'hAB00);
    prog.push_back(16'hBB80);
    prog.push_back(16'h5CBF);
    prog.push_back(16'hF000);
    load_program();
    apply_stimulus(0);
    check_output("dir_r2_add", dut.rf[2], 16'h2468);
    check_output("dir_r3_sat", dut.rf[3], 16'h7FFF);
    check_output("dir_r5_lw", dut.rf[5], 16'h7FFF);
    check_output("dir_dmem_w2", dut.dmem[2], 16'h7FFF);
    check_output("dir_r4_sub", dut.rf[4], 16'h0000);
    check_output("dir_r7_pcs", dut.rf[7], 16'h0042);
    check_output("dir_r8_paddsb", dut.rf[8], 16'h7777);
    check_output("dir_r12_sra", dut.rf[12], 16'hFFFF);
    check_output("dir_halt_pc", pc, 16'h0052);
    reset_while_halted();

    for (int p = 0; p < 8; p++) begin
      gen_program(p == 0);
      load_program();
      if (p == 0) apply_stimulus(5);
      apply_stimulus(0);
      reset_while_halted();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
